// File: rtl/ppu_compress.sv
`default_nettype none
// ============================================================================
// Module   : ppu_compress
// Purpose  : Post-processing scan of the accumulator buffer: shift, ReLU,
//            saturate, zero-run compress, write (value, index) pairs to OARAM.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_compress #(
  parameter int BANK_COUNT  = 32,
  parameter int TILE_SIZE   = 128,
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [$clog2(BANK_COUNT*TILE_SIZE):0]    active_count,
  input  logic [1:0]                               bitwidth,
  input  logic [2:0]                               output_shift,
  output logic [$clog2(BANK_COUNT)-1:0]            buffer_bank_read,
  output logic [$clog2(TILE_SIZE)-1:0]             buffer_bank_entry,
  input  logic signed [VALUE_WIDTH-1:0]            buffer_data_read,
  output logic [VALUE_WIDTH-1:0]                   oaram_value,
  output logic [INDEX_WIDTH-1:0]                   oaram_indices_value,
  output logic [RAM_WIDTH-1:0]                     oaram_address,
  output logic                                     oaram_write_enable,
  input  logic                                     oaram_ready,
  output logic                                     busy,
  output logic                                     cycle_done,
  output logic [RAM_WIDTH:0]                       oaram_count,
  output logic                                     overflow
);

  localparam int                     c_pos_w    = $clog2(BANK_COUNT*TILE_SIZE) + 1;
  localparam int                     c_bank_w   = $clog2(BANK_COUNT);
  localparam logic [INDEX_WIDTH-1:0] c_run_max  = '1;
  localparam logic [RAM_WIDTH:0]     c_capacity = {1'b1, {RAM_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  logic [c_pos_w-1:0]             r_pos;
  logic [c_pos_w-1:0]             r_last_pos;
  logic [2:0]                     r_shift;
  logic [1:0]                     r_bitwidth;
  logic                           r_rd_valid;
  logic                           r_hold_valid;
  logic signed [VALUE_WIDTH-1:0]  r_hold_data;
  logic [INDEX_WIDTH-1:0]         r_run;

  logic                           w_can_proc;
  logic                           w_accept;
  logic                           w_issue;
  logic                           w_last;
  logic                           w_proc;
  logic signed [VALUE_WIDTH-1:0]  w_src_data;
  logic signed [VALUE_WIDTH-1:0]  w_shifted;
  logic [VALUE_WIDTH-1:0]         w_relu;
  logic [VALUE_WIDTH:0]           w_qmax;
  logic [VALUE_WIDTH-1:0]         w_q;
  logic                           w_zero;
  logic                           w_escape;
  logic                           w_emit;
  logic [RAM_WIDTH:0]             w_count_next;
  logic                           w_full;

  // The output slot is free at the end of this cycle unless a write is stalled.
  assign w_can_proc   = !oaram_write_enable || oaram_ready;
  assign w_accept     = oaram_write_enable && oaram_ready;
  assign w_issue      = (r_state == S_SCAN) && w_can_proc;
  assign w_last       = (r_pos == r_last_pos);
  assign w_proc       = (r_hold_valid || r_rd_valid) && w_can_proc;
  assign w_src_data   = r_hold_valid ? r_hold_data : buffer_data_read;

  assign w_shifted    = w_src_data >>> r_shift;
  assign w_relu       = w_shifted[VALUE_WIDTH-1] ? '0 : $unsigned(w_shifted);

  always_comb begin
    w_qmax = (VALUE_WIDTH+1)'(255);
    case (r_bitwidth)
      2'd1:    w_qmax = (VALUE_WIDTH+1)'(15);
      2'd2:    w_qmax = (VALUE_WIDTH+1)'(3);
      2'd3:    w_qmax = (VALUE_WIDTH+1)'(1);
      default: w_qmax = (VALUE_WIDTH+1)'(255);
    endcase
  end

  assign w_q          = ({1'b0, w_relu} > w_qmax) ? w_qmax[VALUE_WIDTH-1:0] : w_relu;
  assign w_zero       = (w_q == '0);
  assign w_escape     = w_zero && (r_run == c_run_max);
  assign w_emit       = w_proc && (!w_zero || w_escape);
  assign w_count_next = oaram_count + (RAM_WIDTH+1)'(w_accept);
  assign w_full       = overflow || (w_count_next == c_capacity);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_pos               <= '0;
      r_last_pos          <= '0;
      r_shift             <= '0;
      r_bitwidth          <= '0;
      r_rd_valid          <= 1'b0;
      r_hold_valid        <= 1'b0;
      r_hold_data         <= '0;
      r_run               <= '0;
      buffer_bank_read    <= '0;
      buffer_bank_entry   <= '0;
      oaram_value         <= '0;
      oaram_indices_value <= '0;
      oaram_address       <= '0;
      oaram_write_enable  <= 1'b0;
      busy                <= 1'b0;
      cycle_done          <= 1'b0;
      oaram_count         <= '0;
      overflow            <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      r_rd_valid <= w_issue;

      if (w_accept) begin
        oaram_count <= w_count_next;
      end

      if (w_proc) begin
        r_run <= (w_zero && !w_escape) ? r_run + 1'b1 : '0;
        if (w_emit && !w_full) begin
          oaram_write_enable  <= 1'b1;
          oaram_value         <= w_q;
          oaram_indices_value <= r_run;
          oaram_address       <= w_count_next[RAM_WIDTH-1:0];
        end else begin
          oaram_write_enable <= 1'b0;
          if (w_emit) begin
            overflow <= 1'b1;
          end
        end
      end else if (w_accept) begin
        oaram_write_enable <= 1'b0;
      end

      // A read returning during a stall is parked until the slot frees up.
      if (!w_can_proc && r_rd_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= buffer_data_read;
      end else if (w_can_proc) begin
        r_hold_valid <= 1'b0;
      end

      if (w_issue && !w_last) begin
        r_pos <= r_pos + 1'b1;
        if (buffer_bank_read == c_bank_w'(BANK_COUNT-1)) begin
          buffer_bank_read  <= '0;
          buffer_bank_entry <= buffer_bank_entry + 1'b1;
        end else begin
          buffer_bank_read  <= buffer_bank_read + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            oaram_count <= '0;
            overflow    <= 1'b0;
            if (active_count != '0) begin
              r_state           <= S_SCAN;
              busy              <= 1'b1;
              r_pos             <= '0;
              r_last_pos        <= active_count - 1'b1;
              r_shift           <= output_shift;
              r_bitwidth        <= bitwidth;
              r_run             <= '0;
              buffer_bank_read  <= '0;
              buffer_bank_entry <= '0;
            end else begin
              cycle_done <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_issue && w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_rd_valid && !r_hold_valid && w_can_proc) begin
            r_state    <= S_DONE;
            busy       <= 1'b0;
            cycle_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_compress
// Purpose  : Directed self-checking bench for ppu_compress with a list-level
//            compression model and a per-cycle write checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_compress;

  localparam int BANKS = 32;
  localparam int TILE  = 128;
  localparam int RAMW  = 2;
  localparam int IDXW  = 4;
  localparam int VW    = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [12:0]        active_count;
  logic [1:0]         bitwidth;
  logic [2:0]         output_shift;
  logic [4:0]         buffer_bank_read;
  logic [6:0]         buffer_bank_entry;
  logic signed [7:0]  buffer_data_read = '0;
  logic [VW-1:0]      oaram_value;
  logic [IDXW-1:0]    oaram_indices_value;
  logic [RAMW-1:0]    oaram_address;
  logic               oaram_write_enable;
  logic               oaram_ready;
  logic               busy;
  logic               cycle_done;
  logic [RAMW:0]      oaram_count;
  logic               overflow;

  ppu_compress #(
    .BANK_COUNT (BANKS),
    .TILE_SIZE  (TILE),
    .RAM_WIDTH  (RAMW),
    .INDEX_WIDTH(IDXW),
    .VALUE_WIDTH(VW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .active_count       (active_count),
    .bitwidth           (bitwidth),
    .output_shift       (output_shift),
    .buffer_bank_read   (buffer_bank_read),
    .buffer_bank_entry  (buffer_bank_entry),
    .buffer_data_read   (buffer_data_read),
    .oaram_value        (oaram_value),
    .oaram_indices_value(oaram_indices_value),
    .oaram_address      (oaram_address),
    .oaram_write_enable (oaram_write_enable),
    .oaram_ready        (oaram_ready),
    .busy               (busy),
    .cycle_done         (cycle_done),
    .oaram_count        (oaram_count),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int v; int idx; int addr; } wr_t;

  logic signed [7:0] lin [0:BANKS*TILE-1];
  wr_t exp_q[$];
  wr_t got_q[$];
  int  exp_count;
  int  exp_ovf;
  int  n_tests = 0;
  int  n_fail  = 0;

  // Accumulator buffer: one-cycle read latency, bank-fastest linear layout.
  always @(posedge clk)
    buffer_data_read <= lin[int'(buffer_bank_entry)*BANKS + int'(buffer_bank_read)];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void build_model(input int cnt, input int bw, input int sh);
    int run;
    int addr;
    int maxv;
    exp_q.delete();
    run = 0; addr = 0; exp_ovf = 0;
    maxv = (1 << (8 >> bw)) - 1;
    for (int p = 0; p < cnt; p++) begin
      int v;
      int q;
      bit emit;
      v = lin[p];
      q = v >>> sh;
      if (q < 0) q = 0;
      if (q > maxv) q = maxv;
      emit = 1'b0;
      if (q != 0) emit = 1'b1;
      else if (run == (1 << IDXW) - 1) emit = 1'b1;
      if (emit) begin
        if (addr < (1 << RAMW)) begin
          exp_q.push_back('{v: q, idx: run, addr: addr});
          addr++;
        end else begin
          exp_ovf = 1;
        end
        run = 0;
      end else begin
        run++;
      end
    end
    exp_count = addr;
  endfunction

  // Per-cycle write checker: every accepted write against the model, and
  // write outputs frozen across every stalled cycle.
  logic        prev_stall = 1'b0;
  logic [14:0] prev_vec   = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", int'({oaram_write_enable, oaram_value, oaram_indices_value, oaram_address}),
              int'(prev_vec));
      if (oaram_write_enable && oaram_ready) begin
        got_q.push_back('{v: int'(oaram_value), idx: int'(oaram_indices_value), addr: int'(oaram_address)});
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_value", int'(oaram_value), e.v);
          check("wr_index", int'(oaram_indices_value), e.idx);
          check("wr_addr", int'(oaram_address), e.addr);
        end
      end
      prev_stall = oaram_write_enable && !oaram_ready;
      prev_vec   = {oaram_write_enable, oaram_value, oaram_indices_value, oaram_address};
    end
  end

  task automatic clear_lin();
    for (int i = 0; i < BANKS*TILE; i++) lin[i] = '0;
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_bank"},  int'(buffer_bank_read), 0);
    check({tag, "_entry"}, int'(buffer_bank_entry), 0);
    check({tag, "_value"}, int'(oaram_value), 0);
    check({tag, "_index"}, int'(oaram_indices_value), 0);
    check({tag, "_addr"},  int'(oaram_address), 0);
    check({tag, "_we"},    int'(oaram_write_enable), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(cycle_done), 0);
    check({tag, "_count"}, int'(oaram_count), 0);
    check({tag, "_ovf"},   int'(overflow), 0);
  endtask

  task automatic check_wr(input int i, input int v, input int idx, input int addr);
    if (i < got_q.size()) begin
      check($sformatf("lit_wr%0d_value", i), got_q[i].v, v);
      check($sformatf("lit_wr%0d_index", i), got_q[i].idx, idx);
      check($sformatf("lit_wr%0d_addr", i), got_q[i].addr, addr);
    end else begin
      check($sformatf("lit_wr%0d_present", i), 0, 1);
    end
  endtask

  task automatic run_scan(input string name, input int cnt, input int bw, input int sh,
                          input int stall_from, input int stall_len,
                          input int lit_done, input int lit_first,
                          input int lit_count, input int lit_ovf);
    int cyc;
    int done_cyc;
    int first_we;
    build_model(cnt, bw, sh);
    got_q.delete();
    @(posedge clk); #1;
    active_count = 13'(cnt);
    bitwidth     = 2'(bw);
    output_shift = 3'(sh);
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    active_count = '0;
    bitwidth     = '0;
    output_shift = '0;
    done_cyc = -1;
    first_we = -1;
    cyc = 1;
    while (cyc < 200) begin
      oaram_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clk);
      if (cyc == 1) begin
        check({name, "_busy_t1"},  int'(busy), 1);
        check({name, "_bank_t1"},  int'(buffer_bank_read), 0);
        check({name, "_entry_t1"}, int'(buffer_bank_entry), 0);
      end
      if (oaram_write_enable && first_we < 0) first_we = cyc;
      if (cycle_done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    oaram_ready = 1'b1;
    check({name, "_done_cycle"}, done_cyc, lit_done);
    check({name, "_first_write"}, first_we, lit_first);
    check({name, "_count"}, int'(oaram_count), exp_count);
    check({name, "_model_count"}, exp_count, lit_count);
    check({name, "_ovf"}, int'(overflow), exp_ovf);
    check({name, "_model_ovf"}, exp_ovf, lit_ovf);
    check({name, "_writes_seen"}, got_q.size(), lit_count);
    check({name, "_missing_writes"}, exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_done_pulse"}, int'(cycle_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset        = 1'b1;
    start        = 1'b0;
    active_count = '0;
    bitwidth     = '0;
    output_shift = '0;
    oaram_ready  = 1'b1;
    clear_lin();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: basic compression
    clear_lin();
    lin[1] = 8'sd5; lin[4] = -8'sd3; lin[5] = 8'sd7;
    run_scan("t1", 8, 0, 0, 1000, 0, 11, 4, 2, 0);
    check_wr(0, 5, 1, 0);
    check_wr(1, 7, 3, 1);

    // Test 2: saturation and shift at 4-bit
    clear_lin();
    lin[0] = 8'sd40; lin[1] = 8'sd2; lin[2] = -8'sd1; lin[3] = 8'sd1;
    run_scan("t2", 4, 1, 1, 1000, 0, 7, 3, 2, 0);
    check_wr(0, 15, 0, 0);
    check_wr(1, 1, 0, 1);

    // Test 3: zero-run escape
    clear_lin();
    lin[20] = 8'sd9;
    run_scan("t3", 21, 0, 0, 1000, 0, 24, 18, 2, 0);
    check_wr(0, 0, 15, 0);
    check_wr(1, 9, 4, 1);

    // Test 4: back-pressure on the first write
    clear_lin();
    lin[1] = 8'sd5; lin[4] = -8'sd3; lin[5] = 8'sd7;
    run_scan("t4", 8, 0, 0, 4, 5, 16, 4, 2, 0);
    check_wr(0, 5, 1, 0);
    check_wr(1, 7, 3, 1);

    // Test 5: OARAM overflow with capacity 4
    clear_lin();
    for (int i = 0; i < 6; i++) lin[i] = 8'(i + 1);
    run_scan("t5", 6, 0, 0, 1000, 0, 9, 3, 4, 1);
    check_wr(0, 1, 0, 0);
    check_wr(3, 4, 0, 3);

    // Crossing a bank wrap, 2-bit saturation, escape mid-stream
    clear_lin();
    lin[3] = 8'sd100; lin[33] = 8'sd9; lin[39] = -8'sd128;
    run_scan("t7", 40, 2, 2, 1000, 0, 43, 6, 3, 0);
    check_wr(0, 3, 3, 0);
    check_wr(1, 0, 15, 1);
    check_wr(2, 2, 13, 2);

    // 1-bit activations
    clear_lin();
    lin[0] = 8'sd1; lin[2] = 8'sd2; lin[3] = -8'sd5;
    run_scan("t8", 6, 3, 0, 1000, 0, 9, 3, 2, 0);
    check_wr(0, 1, 0, 0);
    check_wr(1, 1, 1, 1);

    // Test 6: reset mid-scan, then an empty scan
    clear_lin();
    lin[1] = 8'sd5; lin[4] = -8'sd3; lin[5] = 8'sd7;
    build_model(8, 0, 0);
    @(posedge clk); #1;
    active_count = 13'd8;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_outputs_idle("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (cycle_done || oaram_write_enable || busy) bad++;
    end
    check("after_reset_quiet", bad, 0);

    @(posedge clk); #1;
    active_count = '0;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    @(negedge clk);
    check("empty_done_t1", int'(cycle_done), 1);
    check("empty_count", int'(oaram_count), 0);
    check("empty_we", int'(oaram_write_enable), 0);
    check("empty_busy", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("empty_done_pulse", int'(cycle_done), 0);
    check("empty_no_write", int'(oaram_write_enable), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
